// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add multiplier feeding the ALU MUL result input.
// It runs one partial product per clock for WIDTH clocks and registers the
// 2*WIDTH product as a low word (Product) and a high word (ProductHigh).
// Optional macro ALU_MUL_SIGNED_EN selects two's-complement operands. When the
// macro is undefined the block does an unsigned multiply only.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] ProductHigh,
  output logic             Overflow
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // The low half of acc doubles as the multiplier shift register.
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH:0]   sum;
  logic [AW-1:0]    acc_step;
  logic [AW-1:0]    result;
  logic             ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef ALU_MUL_SIGNED_EN
  logic neg;
`endif

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control; Start is honoured only in IDLE or DONE.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
`ifdef ALU_MUL_SIGNED_EN
    a_mag = A[WIDTH-1] ? (-A) : A;
    b_mag = B[WIDTH-1] ? (-B) : B;
`else
    a_mag = A;
    b_mag = B;
`endif
  end

  // One shift-add step with a WIDTH+1 bit adder, plus final sign fix-up and overflow.
  always_comb begin
    sum      = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_step = {sum, acc[WIDTH-1:1]};
`ifdef ALU_MUL_SIGNED_EN
    result   = neg ? (-acc_step) : acc_step;
    ovf      = (result[AW-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
`else
    result   = acc_step;
    ovf      = |result[AW-1:WIDTH];
`endif
  end

  // Iteration registers: operand latch, accumulator and step counter.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
`ifdef ALU_MUL_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, b_mag};
      mcand <= a_mag;
      cnt   <= CW'(WIDTH);
`ifdef ALU_MUL_SIGNED_EN
      neg   <= A[WIDTH-1] ^ B[WIDTH-1];
`endif
    end else if (step) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
    end
  end

  // Registered outputs; results change only on the final RUN step.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Product     <= '0;
      ProductHigh <= '0;
      Overflow    <= 1'b0;
    end else begin
      Busy <= (state_n == RUN);
      Done <= (state_n == DONE);
      if (last) begin
        Product     <= result[WIDTH-1:0];
        ProductHigh <= result[AW-1:WIDTH];
        Overflow    <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed self-checking bench for alu_mul_seq (WIDTH=24).
module tb_alu_mul_seq;

  localparam int unsigned W = 24;

  logic         Clock;
  logic         ResetN;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Product;
  logic [W-1:0] ProductHigh;
  logic         Overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ov;
  } vec_t;

  alu_mul_seq #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .Start      (Start),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .Product    (Product),
    .ProductHigh(ProductHigh),
    .Overflow   (Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Busy and Done must never be high together.
  always @(negedge Clock) begin
    checks++;
    if (Busy && Done) begin
      failures++;
      $display("FAIL busy_done_overlap: Busy=%0b Done=%0b required not both 1", Busy, Done);
    end
  end

  // Drive a one-cycle Start; returns at the negedge following the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    A     = a;
    B     = b;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Counts Busy cycles until Done, bounded; returns on the Done negedge.
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cycles++;
      @(negedge Clock);
    end
  endtask

  task automatic check_result(input string name, input vec_t v);
    checks++;
    if (Product !== v.lo) begin
      failures++;
      $display("FAIL %s_product: got %h required %h", name, Product, v.lo);
    end
    checks++;
    if (ProductHigh !== v.hi) begin
      failures++;
      $display("FAIL %s_high: got %h required %h", name, ProductHigh, v.hi);
    end
    checks++;
    if (Overflow !== v.ov) begin
      failures++;
      $display("FAIL %s_overflow: got %b required %b", name, Overflow, v.ov);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int bc;
    bit seen;
    launch(v.a, v.b);
    wait_done(bc, seen);
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_timeout: Done seen=%0b required 1", name, seen);
    end
    checks++;
    if (bc != 24) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d required 24", name, bc);
    end
    check_result(name, v);
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: Done=%b one cycle later required 0", name, Done);
    end
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    Start  = 1'b0;
    A      = '0;
    B      = '0;
    #12;
    checks++;
    if ({Busy, Done, Overflow} !== 3'b000 || Product !== '0 || ProductHigh !== '0) begin
      failures++;
      $display("FAIL reset_outputs: Busy=%b Done=%b P=%h PH=%h Ov=%b required all 0",
               Busy, Done, Product, ProductHigh, Overflow);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: Busy=%b Done=%b required 0 0", Busy, Done);
    end
  endtask

  task automatic test_basic;
    vec_t v[3];
    v[0] = '{a: 24'd3,       b: 24'd5,       lo: 24'd15, hi: 24'd0, ov: 1'b0};
    v[1] = '{a: 24'h123456,  b: 24'h000000,  lo: 24'd0,  hi: 24'd0, ov: 1'b0};
    v[2] = '{a: 24'h001000,  b: 24'h000100,  lo: 24'h100000, hi: 24'd0, ov: 1'b0};
    for (int i = 0; i < 3; i++) run_vec($sformatf("basic%0d", i), v[i]);
  endtask

  task automatic test_boundary;
    vec_t v;
`ifdef ALU_MUL_SIGNED_EN
    v = '{a: 24'hFFFFFF, b: 24'hFFFFFF, lo: 24'h000001, hi: 24'h000000, ov: 1'b0};
    run_vec("signed_m1xm1", v);
    v = '{a: 24'h800000, b: 24'h000002, lo: 24'h000000, hi: 24'hFFFFFF, ov: 1'b1};
    run_vec("signed_minx2", v);
    v = '{a: 24'h000003, b: 24'hFFFFFB, lo: 24'hFFFFF1, hi: 24'hFFFFFF, ov: 1'b0};
    run_vec("signed_3xm5", v);
`else
    v = '{a: 24'hFFFFFF, b: 24'hFFFFFF, lo: 24'h000001, hi: 24'hFFFFFE, ov: 1'b1};
    run_vec("unsigned_max", v);
    v = '{a: 24'h800000, b: 24'h000002, lo: 24'h000000, hi: 24'h000001, ov: 1'b1};
    run_vec("unsigned_msbx2", v);
`endif
  endtask

  task automatic test_ignored_start;
    int bc;
    bit seen;
    vec_t v;
    v = '{a: 24'd100, b: 24'd200, lo: 24'd20000, hi: 24'd0, ov: 1'b0};
    launch(v.a, v.b);
    repeat (9) @(negedge Clock);
    A     = 24'd7;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL ignored_busy: Busy=%b after RUN start required 1", Busy);
    end
    wait_done(bc, seen);
    checks++;
    if (seen !== 1'b1 || bc != 14) begin
      failures++;
      $display("FAIL ignored_latency: seen=%0b remaining busy=%0d required 1 and 14", seen, bc);
    end
    check_result("ignored", v);
    @(negedge Clock);
  endtask

  task automatic test_back_to_back;
    int bc;
    bit seen;
    vec_t v1;
    vec_t v2;
    v1 = '{a: 24'h001000, b: 24'h001000, lo: 24'h000000, hi: 24'h000001, ov: 1'b1};
    v2 = '{a: 24'd2, b: 24'd2, lo: 24'd4, hi: 24'd0, ov: 1'b0};
    launch(v1.a, v1.b);
    wait_done(bc, seen);
    check_result("b2b_first", v1);
    A     = v2.a;
    B     = v2.b;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: Busy=%b Done=%b required 1 0", Busy, Done);
    end
    check_result("b2b_hold", v1);
    wait_done(bc, seen);
    checks++;
    if (seen !== 1'b1 || bc != 24) begin
      failures++;
      $display("FAIL b2b_latency: seen=%0b busy=%0d required 1 and 24", seen, bc);
    end
    check_result("b2b_second", v2);
    @(negedge Clock);
  endtask

  task automatic test_reset_mid;
    vec_t v;
    v = '{a: 24'd6, b: 24'd7, lo: 24'd42, hi: 24'd0, ov: 1'b0};
    launch(24'd9, 24'd9);
    repeat (11) @(negedge Clock);
    @(posedge Clock);
    #1;
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: Busy=%b before reset required 1", Busy);
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Overflow} !== 3'b000 || Product !== '0 || ProductHigh !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: Busy=%b Done=%b P=%h PH=%h Ov=%b required all 0",
               Busy, Done, Product, ProductHigh, Overflow);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_aborted: Busy=%b after release required 0", Busy);
    end
    run_vec("after_reset", v);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
